// File: rtl/xenoa_pkg.sv
// Shared types for the XENOA anomaly tracker: semantic keys, tracker states
// and the 101-bit event record carried through the alert queue.
package xenoa_pkg;

  localparam logic [31:0] KEY_NONE        = 32'd0;
  localparam logic [31:0] KEY_SI_DRIFT    = 32'd1;
  localparam logic [31:0] KEY_PI_DRIFT    = 32'd2;
  localparam logic [31:0] KEY_CLK_JITTER  = 32'd3;
  localparam logic [31:0] KEY_THERMAL     = 32'd4;
  localparam logic [31:0] KEY_LINK_MARGIN = 32'd5;
  localparam logic [31:0] KEY_MICRO_EVENT = 32'd6;

  typedef logic [1:0] trk_state_t;
  localparam trk_state_t ST_NORMAL  = 2'd0;
  localparam trk_state_t ST_SUSPECT = 2'd1;
  localparam trk_state_t ST_ALARM   = 2'd2;
  localparam trk_state_t ST_RECOVER = 2'd3;

  localparam logic EV_CLEAR = 1'b0;
  localparam logic EV_RAISE = 1'b1;

  typedef struct packed {
    logic [31:0] key;
    logic        kind;
    logic [3:0]  severity;
    logic [31:0] deviation;
    logic [31:0] timestamp;
  } xenoa_event_t;

  function automatic xenoa_event_t make_event(input logic [31:0] key, input logic kind,
                                              input logic [3:0] sev, input logic [31:0] dev,
                                              input logic [31:0] ts);
    xenoa_event_t ev;
    ev.key       = key;
    ev.kind      = kind;
    ev.severity  = sev;
    ev.deviation = dev;
    ev.timestamp = ts;
    return ev;
  endfunction

endpackage

// File: rtl/xenoa_anomaly_tracker_fifo.sv
// First-word-fall-through event queue; a push into a full queue succeeds
// only when a pop frees a slot at the same edge.
module xenoa_event_fifo
  import xenoa_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  xenoa_event_t data_i,
  input  logic         pop_i,
  output xenoa_event_t head_o,
  output logic         empty_o,
  output logic         full_o,
  output logic [LW-1:0] level_o
);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push, do_pop;
  xenoa_event_t  mem_q [DEPTH];

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/xenoa_anomaly_tracker.sv
// Per-key persistence/hysteresis tracker: sustained excursions raise alarms,
// sustained recovery clears them, and each transition is queued as an event.
module xenoa_anomaly_tracker
  import xenoa_pkg::*;
#(
  parameter int NUM_CH     = 6,
  parameter int PERSIST_N  = 3,
  parameter int CLEAR_N    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        semantic_valid,
  input  logic [31:0]                 semantic_key,
  input  logic [3:0]                  severity,
  input  logic [31:0]                 deviation,
  output logic                        alert_valid,
  input  logic                        alert_ready,
  output logic [31:0]                 alert_key,
  output logic                        alert_kind,
  output logic [3:0]                  alert_severity,
  output logic [31:0]                 alert_deviation,
  output logic [31:0]                 alert_timestamp,
  output logic [NUM_CH-1:0]           active_mask,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [DROP_W-1:0]           drop_count,
  output logic [DROP_W-1:0]           ignore_count
);

  localparam int CNT_MAX = (PERSIST_N > CLEAR_N) ? PERSIST_N : CLEAR_N;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  trk_state_t        state_q  [NUM_CH], state_d  [NUM_CH];
  logic [CNT_W-1:0]  cnt_q    [NUM_CH], cnt_d    [NUM_CH];
  logic [3:0]        peak_q   [NUM_CH], peak_d   [NUM_CH];
  logic [31:0]       maxdev_q [NUM_CH], maxdev_d [NUM_CH];
  logic [31:0]       ts_q;
  logic [DROP_W-1:0] drop_q, ign_q;

  logic         push, pop, drop, ignore, oor;
  logic         ev_kind;
  logic [3:0]   ev_sev, pk_n;
  logic [31:0]  ev_dev, md_n;
  logic [CNT_W-1:0] cnt_inc;
  xenoa_event_t ev_d, fifo_head, head;
  logic         fifo_empty, fifo_full;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign ignore = semantic_valid &&
                  ((semantic_key == KEY_NONE) || (semantic_key > 32'(NUM_CH)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    peak_d   = peak_q;
    maxdev_d = maxdev_q;
    push     = 1'b0;
    ev_kind  = EV_RAISE;
    ev_sev   = '0;
    ev_dev   = '0;
    pk_n     = '0;
    md_n     = '0;
    cnt_inc  = '0;
    oor      = (severity != 4'd0);
    for (int k = 0; k < NUM_CH; k++) begin
      if (semantic_valid && (semantic_key == 32'(k + 1))) begin
        // Episode statistics only absorb out-of-range samples.
        pk_n    = (oor && (severity > peak_q[k])) ? severity : peak_q[k];
        md_n    = (oor && (deviation > maxdev_q[k])) ? deviation : maxdev_q[k];
        cnt_inc = cnt_q[k] + CNT_W'(1);
        case (state_q[k])
          ST_NORMAL: begin
            if (oor) begin
              peak_d[k]   = severity;
              maxdev_d[k] = deviation;
              if (PERSIST_N == 1) begin
                state_d[k] = ST_ALARM;
                cnt_d[k]   = '0;
                push       = 1'b1;
                ev_kind    = EV_RAISE;
                ev_sev     = severity;
                ev_dev     = deviation;
              end else begin
                state_d[k] = ST_SUSPECT;
                cnt_d[k]   = CNT_W'(1);
              end
            end
          end
          ST_SUSPECT: begin
            if (oor) begin
              peak_d[k]   = pk_n;
              maxdev_d[k] = md_n;
              if (cnt_inc == CNT_W'(PERSIST_N)) begin
                state_d[k] = ST_ALARM;
                cnt_d[k]   = '0;
                push       = 1'b1;
                ev_kind    = EV_RAISE;
                ev_sev     = pk_n;
                ev_dev     = md_n;
              end else begin
                cnt_d[k] = cnt_inc;
              end
            end else begin
              state_d[k]  = ST_NORMAL;
              cnt_d[k]    = '0;
              peak_d[k]   = '0;
              maxdev_d[k] = '0;
            end
          end
          ST_ALARM: begin
            if (oor) begin
              peak_d[k]   = pk_n;
              maxdev_d[k] = md_n;
            end else if (CLEAR_N == 1) begin
              state_d[k]  = ST_NORMAL;
              cnt_d[k]    = '0;
              peak_d[k]   = '0;
              maxdev_d[k] = '0;
              push        = 1'b1;
              ev_kind     = EV_CLEAR;
              ev_sev      = peak_q[k];
              ev_dev      = maxdev_q[k];
            end else begin
              state_d[k] = ST_RECOVER;
              cnt_d[k]   = CNT_W'(1);
            end
          end
          default: begin
            if (oor) begin
              state_d[k]  = ST_ALARM;
              cnt_d[k]    = '0;
              peak_d[k]   = pk_n;
              maxdev_d[k] = md_n;
            end else if (cnt_inc == CNT_W'(CLEAR_N)) begin
              state_d[k]  = ST_NORMAL;
              cnt_d[k]    = '0;
              peak_d[k]   = '0;
              maxdev_d[k] = '0;
              push        = 1'b1;
              ev_kind     = EV_CLEAR;
              ev_sev      = peak_q[k];
              ev_dev      = maxdev_q[k];
            end else begin
              cnt_d[k] = cnt_inc;
            end
          end
        endcase
      end
    end
  end

  assign ev_d = make_event(semantic_key, ev_kind, ev_sev, ev_dev, ts_q);
  assign pop  = alert_valid && alert_ready;
  // A full queue only loses the event when nothing drains at the same edge.
  assign drop = push && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k]  <= ST_NORMAL;
        cnt_q[k]    <= '0;
        peak_q[k]   <= '0;
        maxdev_q[k] <= '0;
      end
      ts_q   <= '0;
      drop_q <= '0;
      ign_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      peak_q   <= peak_d;
      maxdev_q <= maxdev_d;
      ts_q     <= ts_q + 32'd1;
      if (drop)   drop_q <= sat_inc(drop_q);
      if (ignore) ign_q  <= sat_inc(ign_q);
    end
  end

  xenoa_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (ev_d),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  assign head            = fifo_empty ? '0 : fifo_head;
  assign alert_valid     = !fifo_empty;
  assign alert_key       = head.key;
  assign alert_kind      = head.kind;
  assign alert_severity  = head.severity;
  assign alert_deviation = head.deviation;
  assign alert_timestamp = head.timestamp;
  assign drop_count      = drop_q;
  assign ignore_count    = ign_q;

  always_comb begin
    active_mask = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      active_mask[k] = (state_q[k] == ST_ALARM) || (state_q[k] == ST_RECOVER);
    end
  end

endmodule

// File: tb/tb_xenoa_anomaly_tracker.sv
// Directed bench for the anomaly tracker: streak-based reference model with a
// per-cycle output compare, plus literal expectations at key points.
`timescale 1ns/1ps
module tb_xenoa_anomaly_tracker;
  import xenoa_pkg::*;

  localparam int NUM_CH = 6;
  localparam int PN     = 3;
  localparam int CN     = 4;
  localparam int DEPTH  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        semantic_valid = 1'b0;
  logic [31:0] semantic_key = '0;
  logic [3:0]  severity = '0;
  logic [31:0] deviation = '0;
  logic        alert_ready = 1'b0;
  logic        alert_valid, alert_kind;
  logic [31:0] alert_key, alert_deviation, alert_timestamp;
  logic [3:0]  alert_severity;
  logic [NUM_CH-1:0] active_mask;
  logic [3:0]  fifo_level;
  logic [15:0] drop_count, ignore_count;

  xenoa_anomaly_tracker dut (
    .clk(clk), .rst_n(rst_n), .semantic_valid(semantic_valid), .semantic_key(semantic_key),
    .severity(severity), .deviation(deviation), .alert_valid(alert_valid),
    .alert_ready(alert_ready), .alert_key(alert_key), .alert_kind(alert_kind),
    .alert_severity(alert_severity), .alert_deviation(alert_deviation),
    .alert_timestamp(alert_timestamp), .active_mask(active_mask), .fifo_level(fifo_level),
    .drop_count(drop_count), .ignore_count(ignore_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: alarm flag plus the length of the current streak that
  // argues against the present alarm status.
  bit           m_alarm [NUM_CH];
  int           m_run   [NUM_CH];
  logic [3:0]   m_pk    [NUM_CH];
  logic [31:0]  m_md    [NUM_CH];
  xenoa_event_t q[$];
  logic [15:0]  m_drop = '0;
  logic [15:0]  m_ign = '0;
  logic [31:0]  m_ts = '0;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_alarm[i] = 0; m_run[i] = 0; m_pk[i] = '0; m_md[i] = '0;
    end
    q.delete();
    m_drop = '0; m_ign = '0; m_ts = '0;
  endtask

  task automatic model_step();
    xenoa_event_t ev;
    bit have_ev, was_full, do_pop, oor;
    int c;
    ev = '0; have_ev = 0;
    was_full = (q.size() == DEPTH);
    do_pop = (q.size() != 0) && alert_ready;
    if (semantic_valid) begin
      if (semantic_key >= 32'd1 && semantic_key <= 32'(NUM_CH)) begin
        c = int'(semantic_key) - 1;
        oor = (severity != 0);
        if (oor) begin
          if (severity > m_pk[c]) m_pk[c] = severity;
          if (deviation > m_md[c]) m_md[c] = deviation;
        end
        if (!m_alarm[c]) begin
          if (oor) begin
            m_run[c]++;
            if (m_run[c] >= PN) begin
              m_alarm[c] = 1; m_run[c] = 0; have_ev = 1;
              ev.key = semantic_key; ev.kind = 1'b1; ev.severity = m_pk[c];
              ev.deviation = m_md[c]; ev.timestamp = m_ts;
            end
          end else begin
            m_run[c] = 0; m_pk[c] = '0; m_md[c] = '0;
          end
        end else if (oor) begin
          m_run[c] = 0;
        end else begin
          m_run[c]++;
          if (m_run[c] >= CN) begin
            have_ev = 1;
            ev.key = semantic_key; ev.kind = 1'b0; ev.severity = m_pk[c];
            ev.deviation = m_md[c]; ev.timestamp = m_ts;
            m_alarm[c] = 0; m_run[c] = 0; m_pk[c] = '0; m_md[c] = '0;
          end
        end
      end else if (m_ign != 16'hFFFF) begin
        m_ign = m_ign + 16'd1;
      end
    end
    if (do_pop) void'(q.pop_front());
    if (have_ev) begin
      if (was_full && !do_pop) begin
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end else begin
        q.push_back(ev);
      end
    end
    m_ts = m_ts + 32'd1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare against the model.
  initial begin
    xenoa_event_t exp;
    logic [NUM_CH-1:0] mmask;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_valid", alert_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_mask", active_mask, 0);
        chk("rst_key", alert_key, 0);
      end else begin
        exp = (q.size() != 0) ? q[0] : '0;
        for (int i = 0; i < NUM_CH; i++) mmask[i] = m_alarm[i];
        chk("valid", alert_valid, q.size() != 0);
        chk("key", alert_key, exp.key);
        chk("kind", alert_kind, exp.kind);
        chk("sev", alert_severity, exp.severity);
        chk("dev", alert_deviation, exp.deviation);
        chk("ts", alert_timestamp, exp.timestamp);
        chk("level", fifo_level, q.size());
        chk("mask", active_mask, mmask);
        chk("drop", drop_count, m_drop);
        chk("ignore", ignore_count, m_ign);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_n(input int n);
    repeat (n) begin
      @(negedge clk); #2;
      semantic_valid = 1'b0;
    end
  endtask

  task automatic set_in(input logic [31:0] k, input logic [3:0] s, input logic [31:0] d);
    semantic_valid = 1'b1; semantic_key = k; severity = s; deviation = d;
  endtask

  task automatic sample_next(input logic [31:0] k, input logic [3:0] s, input logic [31:0] d);
    @(negedge clk); #2;
    set_in(k, s, d);
  endtask

  task automatic sample_at(input logic [31:0] t, input logic [31:0] k, input logic [3:0] s,
                           input logic [31:0] d);
    int guard;
    guard = 0;
    @(negedge clk); #2;
    while (m_ts != t && guard < 200) begin
      semantic_valid = 1'b0;
      @(negedge clk); #2;
      guard++;
    end
    if (m_ts != t) begin
      n_chk++;
      $display("FAIL reach_ts: at ts %0d, wanted %0d", m_ts, t);
    end
    set_in(k, s, d);
  endtask

  task automatic burst(input logic [31:0] k, input logic [3:0] s, input logic [31:0] d,
                       input int n);
    repeat (n) sample_next(k, s, d);
  endtask

  initial begin
    idle_n(2);
    chk("init_valid", alert_valid, 0);
    chk("init_drop", drop_count, 0);
    chk("init_ignore", ignore_count, 0);
    rst_n = 1'b1;
    alert_ready = 1'b1;

    // Raise
    sample_at(10, 2, 12, 5);
    sample_at(11, 2, 12, 9);
    sample_at(12, 2, 12, 7);
    idle_n(1);
    chk("raise_valid", alert_valid, 1);
    chk("raise_key", alert_key, 2);
    chk("raise_kind", alert_kind, 1);
    chk("raise_sev", alert_severity, 12);
    chk("raise_dev", alert_deviation, 9);
    chk("raise_ts", alert_timestamp, 12);
    chk("raise_mask", active_mask, 6'b000010);

    // Clear
    for (int t = 20; t < 24; t++) sample_at(t, 2, 0, 0);
    idle_n(1);
    chk("clear_valid", alert_valid, 1);
    chk("clear_kind", alert_kind, 0);
    chk("clear_sev", alert_severity, 12);
    chk("clear_dev", alert_deviation, 9);
    chk("clear_ts", alert_timestamp, 23);
    chk("clear_mask", active_mask, 0);

    // Hysteresis
    sample_at(25, 2, 3, 100);
    sample_at(26, 2, 3, 1);
    sample_at(27, 2, 3, 1);
    sample_at(30, 2, 0, 0);
    sample_at(31, 2, 0, 0);
    sample_at(32, 2, 8, 50);
    idle_n(1);
    chk("hyst_valid", alert_valid, 0);
    chk("hyst_mask", active_mask, 6'b000010);
    for (int t = 40; t < 44; t++) sample_at(t, 2, 0, 0);
    idle_n(1);
    chk("hyst_clr_kind", alert_kind, 0);
    chk("hyst_clr_sev", alert_severity, 8);
    chk("hyst_clr_dev", alert_deviation, 100);
    chk("hyst_clr_ts", alert_timestamp, 43);
    sample_at(50, 3, 5, 1);
    sample_at(51, 3, 5, 1);
    sample_at(52, 3, 0, 0);
    sample_at(53, 3, 5, 1);
    sample_at(54, 3, 0, 0);
    idle_n(1);
    chk("dip_valid", alert_valid, 0);
    chk("dip_mask", active_mask, 0);

    // Ignore and interleave
    sample_at(60, 0, 9, 1);
    sample_at(61, 7, 9, 1);
    idle_n(1);
    chk("ign_count", ignore_count, 2);
    chk("ign_mask", active_mask, 0);
    sample_at(63, 1, 1, 11);
    sample_at(64, 4, 2, 22);
    sample_at(65, 1, 1, 12);
    sample_at(66, 4, 2, 23);
    sample_at(67, 1, 1, 13);
    sample_at(68, 4, 2, 21);
    idle_n(1);
    chk("il_mask", active_mask, 6'b001001);
    chk("il_key", alert_key, 4);
    chk("il_ts", alert_timestamp, 68);
    chk("il_dev", alert_deviation, 23);
    idle_n(1);
    alert_ready = 1'b0;

    // Overflow
    burst(5, 4, 50, 3);
    burst(6, 5, 60, 3);
    burst(1, 0, 0, 4);
    burst(4, 0, 0, 4);
    burst(5, 0, 0, 4);
    burst(6, 0, 0, 4);
    burst(1, 7, 70, 3);
    burst(4, 7, 80, 3);
    burst(5, 4, 50, 3);
    idle_n(1);
    chk("ovf_level", fifo_level, 8);
    chk("ovf_drop", drop_count, 1);
    chk("ovf_key", alert_key, 5);
    chk("ovf_sev", alert_severity, 4);
    burst(6, 9, 90, 2);
    sample_next(6, 9, 90);
    alert_ready = 1'b1;
    idle_n(1);
    alert_ready = 1'b0;
    chk("pp_level", fifo_level, 8);
    chk("pp_drop", drop_count, 1);
    chk("pp_key", alert_key, 6);
    chk("pp_dev", alert_deviation, 60);
    alert_ready = 1'b1;
    idle_n(10);
    chk("drain_level", fifo_level, 0);
    alert_ready = 1'b0;

    // Reset mid-operation
    burst(1, 0, 0, 4);
    burst(4, 0, 0, 4);
    burst(5, 0, 0, 4);
    sample_next(2, 3, 3);
    idle_n(1);
    chk("pre_rst_level", fifo_level, 3);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", alert_valid, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_mask", active_mask, 0);
    chk("arst_drop", drop_count, 0);
    chk("arst_ignore", ignore_count, 0);
    chk("arst_key", alert_key, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    set_in(3, 6, 33);
    sample_at(1, 3, 6, 30);
    sample_at(2, 3, 6, 31);
    idle_n(1);
    chk("post_key", alert_key, 3);
    chk("post_ts", alert_timestamp, 2);
    chk("post_dev", alert_deviation, 33);
    chk("post_mask", active_mask, 6'b000100);
    burst(2, 1, 1, 2);
    idle_n(1);
    chk("post_k2_mask", active_mask, 6'b000100);
    alert_ready = 1'b1;
    idle_n(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
